// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the dot-product accumulator.
// Holds the word geometry, the working significand field width, the FSM
// state encoding and the special bit patterns written on overflow / NaN.
package fp32_pkg;

  localparam int N    = 32;
  localparam int E    = 8;
  localparam int MA   = 23;
  localparam int BIAS = 127;
  localparam int GRS  = 3;

  // Working field {hidden, mant, G, R, S}
  localparam int FW = MA + 1 + GRS;

  // Largest biased exponent; reaching it after rounding means overflow to inf
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [N-1:0] ZERO = 32'h0000_0000;
  localparam logic [N-1:0] INF  = 32'h7F80_0000;
  localparam logic [N-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fp_lzc28.sv
// Combinational 28-bit leading-zero counter used by the NORM stage.
// Ports:
//   data_i  [27:0] value to scan
//   count_o [4:0]  number of zeros above the highest set bit (28 if all zero)
module fp_lzc28
  import fp32_pkg::*;
(
  input  logic [27:0] data_i,
  output logic [4:0]  count_o
);

  // Scan LSB to MSB so the highest set bit wins the last assignment
  always_comb begin
    count_o = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (data_i[i]) count_o = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_dot_accumulator.sv
// Running binary32 accumulator for the multiplier's product stream.
// Each accepted operand is added to the accumulator through a four-step
// datapath (ALIGN, ADD, NORM, ROUND) with round-to-nearest-even; an operand
// flagged in_last ends the vector and its sum is presented on out_data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_data, in_last    binary32 operand and end-of-vector flag
//   out_valid/out_ready result handshake; out_data held until accepted
//   out_data            binary32 sum of the finished vector
// Handshake rule: a transfer occurs on a rising edge where valid and ready
// are both high; the producer keeps valid and its payload stable until then.
module fp_dot_accumulator
  import fp32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam logic [FW-1:0]     F_ONE   = {{(FW-1){1'b0}}, 1'b1};
  localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

  state_t              state_q;
  logic [N-1:0]        op_q, acc_q, out_data_q, special_val_q;
  logic                last_q, in_ready_q, out_valid_q;
  logic                special_q, sign_q, sub_q, zero_q;
  logic signed [9:0]   exp_q;
  logic [FW-1:0]       xf_q, yf_q, norm_q;
  logic [FW:0]         sum_q;

  // ---------------- ALIGN (operand vs accumulator) ----------------
  logic [E-1:0]  op_exp, acc_exp, x_exp, y_exp, exp_diff;
  logic [MA:0]   op_sig, acc_sig, x_sig, y_sig;
  logic          op_inf, acc_inf, swap, x_sign;
  logic [FW-1:0] y_full, y_mask, y_align_d;
  logic          special_d;
  logic [N-1:0]  special_val_d;

  always_comb begin
    op_exp  = op_q[N-2 -: E];
    acc_exp = acc_q[N-2 -: E];
    op_inf  = &op_exp;
    acc_inf = &acc_exp;
    // exp==0 means zero or denormal; both are treated as an exact zero
    op_sig  = (op_exp  == '0) ? '0 : {1'b1, op_q[MA-1:0]};
    acc_sig = (acc_exp == '0) ? '0 : {1'b1, acc_q[MA-1:0]};

    swap   = {op_exp, op_sig[MA-1:0]} > {acc_exp, acc_sig[MA-1:0]};
    x_exp  = swap ? op_exp    : acc_exp;
    y_exp  = swap ? acc_exp   : op_exp;
    x_sig  = swap ? op_sig    : acc_sig;
    y_sig  = swap ? acc_sig   : op_sig;
    x_sign = swap ? op_q[N-1] : acc_q[N-1];

    exp_diff = x_exp - y_exp;
    y_full   = {y_sig, {GRS{1'b0}}};
    y_mask   = '0;
    if (exp_diff >= 8'(FW - 1)) begin
      // Entire smaller significand falls below S: only its presence matters
      y_align_d = {{(FW-1){1'b0}}, |y_sig};
    end else begin
      y_mask    = (F_ONE << exp_diff) - F_ONE;
      y_align_d = (y_full >> exp_diff) | {{(FW-1){1'b0}}, |(y_full & y_mask)};
    end

    // Infinities (NaN included) bypass the arithmetic entirely
    special_d = op_inf | acc_inf;
    if (op_inf && acc_inf) begin
      special_val_d = (op_q[N-1] != acc_q[N-1]) ? QNAN : {op_q[N-1], INF[N-2:0]};
    end else if (op_inf) begin
      special_val_d = {op_q[N-1], INF[N-2:0]};
    end else begin
      special_val_d = acc_q;
    end
  end

  // ---------------- NORM support ----------------
  // Trailing 1 caps the count at FW so it measures the 27-bit field directly
  logic [4:0] lzc;

  fp_lzc28 u_lzc (
    .data_i  ({sum_q[FW-1:0], 1'b1}),
    .count_o (lzc)
  );

  // ---------------- ROUND ----------------
  logic              round_inc;
  logic [MA+1:0]     round_sig;
  logic signed [9:0] round_exp;
  logic [MA-1:0]     round_mant;
  logic [N-1:0]      round_res_d;

  always_comb begin
    round_inc  = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    round_sig  = {1'b0, norm_q[FW-1:GRS]} + {{(MA+1){1'b0}}, round_inc};
    round_exp  = exp_q + $signed({9'd0, round_sig[MA+1]});
    round_mant = round_sig[MA+1] ? round_sig[MA:1] : round_sig[MA-1:0];

    if (special_q) begin
      round_res_d = special_val_q;
    end else if (zero_q) begin
      round_res_d = ZERO;                 // exact cancellation is always +0
    end else if (round_exp >= EXP_SAT) begin
      round_res_d = {sign_q, INF[N-2:0]};
    end else if (round_exp <= 10'sd0) begin
      round_res_d = {sign_q, {(N-1){1'b0}}};
    end else begin
      round_res_d = {sign_q, round_exp[E-1:0], round_mant};
    end
  end

  // ---------------- FSM and datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      last_q        <= 1'b0;
      acc_q         <= ZERO;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      zero_q        <= 1'b0;
      exp_q         <= '0;
      xf_q          <= '0;
      yf_q          <= '0;
      sum_q         <= '0;
      norm_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= in_data;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= ALIGN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ALIGN: begin
          xf_q          <= {x_sig, {GRS{1'b0}}};
          yf_q          <= y_align_d;
          sub_q         <= op_q[N-1] ^ acc_q[N-1];
          sign_q        <= x_sign;
          exp_q         <= $signed({2'b00, x_exp});
          special_q     <= special_d;
          special_val_q <= special_val_d;
          state_q       <= ADD;
        end
        ADD: begin
          sum_q   <= sub_q ? ({1'b0, xf_q} - {1'b0, yf_q})
                           : ({1'b0, xf_q} + {1'b0, yf_q});
          state_q <= NORM;
        end
        NORM: begin
          zero_q <= (sum_q == '0);
          if (sum_q[FW]) begin
            norm_q <= {sum_q[FW:2], sum_q[1] | sum_q[0]};
            exp_q  <= exp_q + 10'sd1;
          end else begin
            norm_q <= sum_q[FW-1:0] << lzc;
            exp_q  <= exp_q - $signed({5'd0, lzc});
          end
          state_q <= ROUND;
        end
        ROUND: begin
          acc_q <= round_res_d;
          if (last_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= round_res_d;
            state_q     <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_q       <= ZERO;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_dot_accumulator.sv
`timescale 1ns/1ps
module tb_fp_dot_accumulator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  fp_dot_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          rand_ready = 1'b0;
  logic [31:0] model_acc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out / unexpected event", name);
  endtask

  // ---------------- reference model ----------------
  // Operand magnitude as an exact integer in units of 2^-149
  function automatic logic [299:0] mag_of(input logic [31:0] v);
    logic [299:0] m;
    if (v[30:23] == 8'h00) return '0;
    m = {276'd0, 1'b1, v[22:0]};
    return m << (v[30:23] - 8'd1);
  endfunction

  // Exact sum, then RNE to 24 significant bits, flush tiny, saturate to inf
  function automatic logic [31:0] ref_add(input logic [31:0] acc, input logic [31:0] op);
    bit ai, oi, s;
    logic [299:0] a, b, m, sig, rem, half;
    int p, sh, e;
    ai = (acc[30:23] == 8'hFF);
    oi = (op[30:23] == 8'hFF);
    if (ai && oi) return (acc[31] != op[31]) ? 32'h7FC00000 : {op[31], 31'h7F800000};
    if (oi) return {op[31], 31'h7F800000};
    if (ai) return acc;
    a = mag_of(acc);
    b = mag_of(op);
    if (acc[31] == op[31]) begin m = a + b; s = acc[31]; end
    else if (a >= b)       begin m = a - b; s = acc[31]; end
    else                   begin m = b - a; s = op[31];  end
    if (m == '0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    e = p - 22;
    if (e <= 0) return {s, 31'h0};
    sh  = p - 23;
    sig = m >> sh;
    if (sh > 0) begin
      rem  = m & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig = sig + 300'd1;
    end
    if (sig[24]) begin sig = sig >> 1; e = e + 1; end
    if (e >= 255) return {s, 31'h7F800000};
    return {s, 8'(e), sig[22:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_op(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    if (!in_ready) begin fail_now("in_ready_wait"); return; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin tick(); guard++; end
    if (exp_q.size() != 0) begin
      fail_now("result_wait");
      exp_q.delete();
    end
  endtask

  // Two-term vector with a hand-computed result; also pins the model
  task automatic run2(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] req);
    check({name, "_model"}, ref_add(ref_add(32'h0, a), b), req);
    exp_q.push_back(req);
    send_op(a, 1'b0);
    send_op(b, 1'b1);
    wait_result();
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [31:0] hold_data = 32'h0;
  bit          hold_pending = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_data);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", out_data, exp_q.pop_front());
      end else if (out_valid) begin
        hold_pending = 1'b1;
        hold_data    = out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_fp();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 19);
    if (k == 0) return {1'($urandom), 8'h00, 23'($urandom)};
    if (k == 1) return {1'($urandom), 8'hFF, ($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'd0};
    if (k == 2) return {~model_acc[31], model_acc[30:0] ^ 31'($urandom_range(0, 3))};
    if (k == 3) e = 8'($urandom_range(240, 254));
    else        e = 8'($urandom_range(110, 140));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] ops[8];
    int len;

    // reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // 1.0 + 2.0 with latency: accept edge is edge 1, out_valid rises on edge 5
    check("t1_model", ref_add(ref_add(32'h0, 32'h3F800000), 32'h40000000), 32'h40400000);
    exp_q.push_back(32'h40400000);
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("latency_edge%0d", k + 1), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    wait_result();

    run2("cancel",      32'h3F800000, 32'hBF800000, 32'h00000000);
    run2("rne_tie",     32'h3F800000, 32'h33800000, 32'h3F800000);
    run2("rne_above",   32'h3F800000, 32'h33800001, 32'h3F800001);
    run2("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    run2("denormal",    32'h00000001, 32'h3F800000, 32'h3F800000);
    run2("sub_tie",     32'h3F800000, 32'hB3000000, 32'h3F800000);
    run2("sub_exact",   32'h3F800000, 32'hB3800000, 32'h3F7FFFFF);
    run2("inf_minus",   32'h7F800000, 32'hFF800000, 32'h7FC00000);
    run2("inf_sticky",  32'h7F800000, 32'h3F800000, 32'h7F800000);
    run2("nan_as_inf",  32'h3F800000, 32'h7FC00001, 32'h7F800000);

    // backpressure in DONE, with in_valid asserted while not ready
    out_ready = 1'b0;
    exp_q.push_back(32'h40800000);
    send_op(32'h40400000, 1'b0);
    send_op(32'h3F800000, 1'b1);
    len = 0;
    while (!out_valid && len < 20) begin tick(); len++; end
    if (!out_valid) fail_now("bp_out_valid");
    in_valid = 1'b1;
    in_data  = 32'h4B000000;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h40800000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_result();
    exp_q.push_back(32'h3F800000);
    send_op(32'h3F800000, 1'b1);
    wait_result();

    // reset while the last term sits in ADD; partial sum must be discarded
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    exp_q.push_back(32'h40A00000);
    send_op(32'h40A00000, 1'b1);
    wait_result();

    // randomized vectors with random out_ready
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      len = $urandom_range(1, 6);
      model_acc = 32'h0;
      for (int i = 0; i < len; i++) begin
        ops[i]    = rand_fp();
        model_acc = ref_add(model_acc, ops[i]);
      end
      exp_q.push_back(model_acc);
      for (int i = 0; i < len; i++) send_op(ops[i], (i == len - 1));
    end
    wait_result();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
